// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared constants and width helpers for the key debouncer
package debounce_pkg;

  // Clocks per millisecond for each MHz of system clock.
  localparam int CLKS_PER_MHZ_MS = 1000;

  // Long-press counter is a fixed 16 bits so LONG_TIME can reach 65535 ms.
  localparam int LONG_W = 16;

  // Defaults matching the top-level parameter defaults.
  localparam int DEF_FREQ        = 50;
  localparam int DEF_MAX_TIME    = 20;
  localparam int DEF_TICK_PERIOD = DEF_FREQ * CLKS_PER_MHZ_MS;
  localparam int DEF_PRESC_W     = $clog2(DEF_TICK_PERIOD);
  localparam int DEF_DBC_W       = $clog2(DEF_MAX_TIME + 1);

  // Number of clocks in one millisecond tick.
  function automatic int tick_period(input int freq_mhz);
    return freq_mhz * CLKS_PER_MHZ_MS;
  endfunction

  // Prescaler width; the counter runs 0..tick_period-1.
  function automatic int presc_width(input int freq_mhz);
    return $clog2(freq_mhz * CLKS_PER_MHZ_MS);
  endfunction

  // Debounce counter width; it must hold the value max_time itself.
  function automatic int dbc_width(input int max_time);
    return $clog2(max_time + 1);
  endfunction

endpackage

// File: rtl/key_debounce_channel.sv
// rtl/key_debounce_channel.sv - one button channel: sync, debounce, edges, long press
module key_debounce_channel
  import debounce_pkg::*;
#(
  parameter int   MAX_TIME   = 20,
  parameter int   LONG_TIME  = 1000,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic tick_ms,
  input  logic button_in,
  output logic button_out,
  output logic button_posedge,
  output logic button_negedge,
  output logic button_long
);

  localparam int                CW       = dbc_width(MAX_TIME);
  localparam logic [CW-1:0]     CNT_MAX  = CW'(MAX_TIME);
  localparam logic [LONG_W-1:0] LONG_MAX = LONG_W'(LONG_TIME);

  logic              s1_q, s1_d;
  logic              s2_q, s2_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              out_q, out_d;
  logic              d0_q, d0_d;
  logic              pos_q, pos_d;
  logic              neg_q, neg_d;
  logic [LONG_W-1:0] lcnt_q, lcnt_d;
  logic              long_q, long_d;

  // Synchroniser and debounce counter: any disagreement between the two sync
  // stages restarts the stability window, which beats a coincident tick.
  always_comb begin
    s1_d  = button_in;
    s2_d  = s1_q;
    cnt_d = cnt_q;
    if (s1_q != s2_q) begin
      cnt_d = '0;
    end else if (tick_ms && (cnt_q < CNT_MAX)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Debounced level and its registered edge pulses.
  always_comb begin
    out_d = out_q;
    if ((cnt_q == CNT_MAX) && (s2_q != out_q)) begin
      out_d = s2_q;
    end
    d0_d  = out_q;
    pos_d = ~d0_q & out_q;
    neg_d = d0_q & ~out_q;
  end

  // Long-press counter keyed off the next debounced level, so a release that
  // lands on the same cycle as the final tick clears instead of firing.
  always_comb begin
    lcnt_d = lcnt_q;
    if (out_d == IDLE_LEVEL) begin
      lcnt_d = '0;
    end else if (tick_ms && (lcnt_q < LONG_MAX)) begin
      lcnt_d = lcnt_q + LONG_W'(1);
    end
    long_d = (lcnt_d == LONG_MAX) && (lcnt_q != LONG_MAX);
  end

  // State register; every flop returns to its idle value on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q   <= IDLE_LEVEL;
      s2_q   <= IDLE_LEVEL;
      cnt_q  <= '0;
      out_q  <= IDLE_LEVEL;
      d0_q   <= IDLE_LEVEL;
      pos_q  <= 1'b0;
      neg_q  <= 1'b0;
      lcnt_q <= '0;
      long_q <= 1'b0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      cnt_q  <= cnt_d;
      out_q  <= out_d;
      d0_q   <= d0_d;
      pos_q  <= pos_d;
      neg_q  <= neg_d;
      lcnt_q <= lcnt_d;
      long_q <= long_d;
    end
  end

  assign button_out     = out_q;
  assign button_posedge = pos_q;
  assign button_negedge = neg_q;
  assign button_long    = long_q;

endmodule

// File: rtl/key_debounce_array.sv
// rtl/key_debounce_array.sv - shared ms prescaler driving CH debounce channels
module key_debounce_array
  import debounce_pkg::*;
#(
  parameter int   CH         = 4,
  parameter int   FREQ       = 50,
  parameter int   MAX_TIME   = 20,
  parameter int   LONG_TIME  = 1000,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CH-1:0] button_in,
  output logic [CH-1:0] button_out,
  output logic [CH-1:0] button_posedge,
  output logic [CH-1:0] button_negedge,
  output logic [CH-1:0] button_long,
  output logic          tick_ms
);

  localparam int            TICK_N    = tick_period(FREQ);
  localparam int            PW        = presc_width(FREQ);
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_N - 1);

  logic [PW-1:0] presc_q, presc_d;

  // Free-running prescaler that wraps after one millisecond.
  always_comb begin
    presc_d = presc_q + PW'(1);
    if (presc_q == TICK_LAST) begin
      presc_d = '0;
    end
  end

  // Prescaler register.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

  assign tick_ms = (presc_q == TICK_LAST);

  for (genvar i = 0; i < CH; i++) begin : g_ch
    key_debounce_channel #(
      .MAX_TIME   (MAX_TIME),
      .LONG_TIME  (LONG_TIME),
      .IDLE_LEVEL (IDLE_LEVEL)
    ) u_ch (
      .clk            (clk),
      .rst            (rst),
      .tick_ms        (tick_ms),
      .button_in      (button_in[i]),
      .button_out     (button_out[i]),
      .button_posedge (button_posedge[i]),
      .button_negedge (button_negedge[i]),
      .button_long    (button_long[i])
    );
  end

endmodule

// File: tb/tb_key_debounce_array.sv
// tb/tb_key_debounce_array.sv - scoreboard bench for key_debounce_array
module tb_key_debounce_array;

  localparam int K_NEG  = 0;
  localparam int K_POS  = 1;
  localparam int K_LONG = 2;

  // Debounce window measured from the cycle an input is driven.
  localparam int DB_LO = 3003;
  localparam int DB_HI = 4004;
  // Long pulse window measured from the negedge pulse of the same channel.
  localparam int LG_LO = 9000;
  localparam int LG_HI = 11000;

  typedef struct {
    int kind;
    int ch;
    int lo;
    int hi;
    bit rel;
  } ev_t;

  logic       clk;
  logic       rst;
  logic [3:0] button_in;
  logic [3:0] button_out;
  logic [3:0] button_posedge;
  logic [3:0] button_negedge;
  logic [3:0] button_long;
  logic       tick_ms;

  int  cyc;
  int  tests;
  int  fails;
  int  t0;
  int  tick_cnt;
  int  last_neg[4];
  int  last_pos[4];
  ev_t exp_q[$];

  logic mon_p;
  bit   mon_found;
  int   mon_sel;
  int   mon_lo;
  int   mon_hi;

  key_debounce_array #(
    .CH         (4),
    .FREQ       (1),
    .MAX_TIME   (4),
    .LONG_TIME  (10),
    .IDLE_LEVEL (1'b1)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .button_in      (button_in),
    .button_out     (button_out),
    .button_posedge (button_posedge),
    .button_negedge (button_negedge),
    .button_long    (button_long),
    .tick_ms        (tick_ms)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_range(input string tag, input int got, input int lo, input int hi);
    tests++;
    assert (((got >= lo) && (got <= hi)) === 1'b1) else begin
      fails++;
      $error("FAIL %s: observed %0d, expected %0d..%0d", tag, got, lo, hi);
    end
  endtask

  task automatic expect_ev(input int kind, input int ch, input int lo, input int hi, input bit rel);
    ev_t e;
    e.kind = kind;
    e.ch   = ch;
    e.lo   = lo;
    e.hi   = hi;
    e.rel  = rel;
    exp_q.push_back(e);
  endtask

  task automatic wait_empty(input int limit);
    for (int i = 0; i < limit; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
    end
    check("pending events", exp_q.size(), 0);
  endtask

  task automatic drive(input int ch, input logic lvl);
    @(posedge clk);
    #1;
    button_in[ch] = lvl;
    t0 = cyc;
  endtask

  // Monitor: every observed pulse must match a queued expectation.
  always @(negedge clk) begin
    if (!rst) begin
      for (int c = 0; c < 4; c++) begin
        for (int k = 0; k < 3; k++) begin
          mon_p = (k == K_NEG) ? button_negedge[c] :
                  (k == K_POS) ? button_posedge[c] : button_long[c];
          if (mon_p) begin
            mon_found = 1'b0;
            mon_sel   = 0;
            for (int j = 0; j < exp_q.size(); j++) begin
              if (!mon_found && exp_q[j].kind == k && exp_q[j].ch == c) begin
                mon_found = 1'b1;
                mon_sel   = j;
              end
            end
            check($sformatf("pulse kind%0d ch%0d expected", k, c), int'(mon_found), 1);
            if (mon_found) begin
              mon_lo = exp_q[mon_sel].lo;
              mon_hi = exp_q[mon_sel].hi;
              if (exp_q[mon_sel].rel) begin
                mon_lo = mon_lo + last_neg[c];
                mon_hi = mon_hi + last_neg[c];
              end
              check_range($sformatf("pulse kind%0d ch%0d cycle", k, c), cyc, mon_lo, mon_hi);
              exp_q.delete(mon_sel);
            end
            if (k == K_NEG) last_neg[c] = cyc;
            if (k == K_POS) last_pos[c] = cyc;
          end
        end
      end
    end
  end

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    button_in = 4'hF;
    for (int i = 0; i < 4; i++) begin
      last_neg[i] = 0;
      last_pos[i] = 0;
    end

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset button_out", button_out, 4'hF);
    check("reset posedge", button_posedge, 0);
    check("reset negedge", button_negedge, 0);
    check("reset long", button_long, 0);
    check("reset tick_ms", tick_ms, 0);
    rst = 1'b0;

    // Idle hold: no pulses, one tick per 1000 clocks
    tick_cnt = 0;
    repeat (20000) begin
      @(negedge clk);
      if (tick_ms) tick_cnt++;
    end
    check("tick count 20000 clk", tick_cnt, 20);
    check("idle button_out", button_out, 4'hF);

    // Clean press on channel 0
    drive(0, 1'b0);
    expect_ev(K_NEG, 0, t0 + DB_LO, t0 + DB_HI, 1'b0);
    wait_empty(5000);
    check("press ch0 button_out", button_out, 4'hE);

    // Reset 2 ms into the debounced press, then fresh detection
    repeat (2000) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst button_out", button_out, 4'hF);
    check("midrst posedge", button_posedge, 0);
    check("midrst negedge", button_negedge, 0);
    check("midrst long", button_long, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    t0 = cyc;
    expect_ev(K_NEG, 0, t0 + DB_LO, t0 + DB_HI, 1'b0);
    wait_empty(5000);
    check("redetect ch0 button_out", button_out, 4'hE);
    drive(0, 1'b1);
    expect_ev(K_POS, 0, t0 + DB_LO, t0 + DB_HI, 1'b0);
    wait_empty(5000);
    check("release ch0 button_out", button_out, 4'hF);

    // Bounce on channel 1: 700-clock toggles never settle
    for (int i = 0; i < 14; i++) begin
      drive(1, (i % 2 == 0) ? 1'b0 : 1'b1);
      repeat (699) @(posedge clk);
    end
    check("bounce ch1 button_out", button_out, 4'hF);
    drive(1, 1'b0);
    expect_ev(K_NEG, 1, t0 + DB_LO, t0 + DB_HI, 1'b0);
    wait_empty(5000);
    check("settled ch1 button_out", button_out, 4'hD);

    // Release ch1 while starting a long press on ch2
    @(posedge clk);
    #1;
    button_in[1] = 1'b1;
    button_in[2] = 1'b0;
    t0 = cyc;
    expect_ev(K_POS, 1, t0 + DB_LO, t0 + DB_HI, 1'b0);
    expect_ev(K_NEG, 2, t0 + DB_LO, t0 + DB_HI, 1'b0);
    expect_ev(K_LONG, 2, LG_LO, LG_HI, 1'b1);
    wait_empty(16000);
    check("long ch2 button_out", button_out, 4'hB);
    drive(2, 1'b1);
    expect_ev(K_POS, 2, t0 + DB_LO, t0 + DB_HI, 1'b0);
    wait_empty(5000);
    repeat (2000) @(posedge clk);
    check("after long button_out", button_out, 4'hF);

    // Simultaneous press on channels 0 and 3
    @(posedge clk);
    #1;
    button_in[0] = 1'b0;
    button_in[3] = 1'b0;
    t0 = cyc;
    expect_ev(K_NEG, 0, t0 + DB_LO, t0 + DB_HI, 1'b0);
    expect_ev(K_NEG, 3, t0 + DB_LO, t0 + DB_HI, 1'b0);
    wait_empty(5000);
    check("simul negedge same cycle", last_neg[3], last_neg[0]);
    check("simul button_out", button_out, 4'h6);
    @(posedge clk);
    #1;
    button_in[0] = 1'b1;
    button_in[3] = 1'b1;
    t0 = cyc;
    expect_ev(K_POS, 0, t0 + DB_LO, t0 + DB_HI, 1'b0);
    expect_ev(K_POS, 3, t0 + DB_LO, t0 + DB_HI, 1'b0);
    wait_empty(5000);
    check("simul posedge same cycle", last_pos[3], last_pos[0]);
    check("final button_out", button_out, 4'hF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/key_debounce_array.md
# key_debounce_array

Parametrised multi-channel key debouncer for push-button inputs on the board I/O path. It synchronises CH asynchronous button inputs and filters each one independently. A single shared millisecond tick paces all channels. Per channel it delivers a debounced level, one-cycle press and release pulses, and a one-shot long-press pulse. It sits between the raw key pins and the control logic that consumes key events.

## Interface
- CH, 4: number of independent button channels (1..32).
- FREQ, 50: clock frequency in MHz; the tick period is FREQ*1000 clocks.
- MAX_TIME, 20: debounce stable time in ms (1..255).
- LONG_TIME, 1000: hold time in ms for a long press (greater than MAX_TIME, at most 65535).
- IDLE_LEVEL, 1'b1: electrical level of a released button; "pressed" means the opposite level.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; one clock; reset is synchronous and active-high.
- button_in  in  CH  raw asynchronous button levels.
- button_out  out  CH  debounced level per channel.
- button_posedge  out  CH  one-cycle pulse when button_out rises 0→1.
- button_negedge  out  CH  one-cycle pulse when button_out falls 1→0.
- button_long  out  CH  one-cycle pulse when a channel has been debounced-pressed for LONG_TIME ticks.
- tick_ms  out  1  one-cycle pulse for the shared 1 ms tick, for use by other blocks.

## Operation
- **Prescaler**
  - Counter runs 0..FREQ*1000-1 and wraps.
  - tick_ms is high for exactly the cycle in which the counter equals FREQ*1000-1.
  - Counter width is $clog2(FREQ*1000).
- **Synchroniser (per channel)**
  - Two flops: s1 <= button_in[i], then s2 <= s1.
  - Both reset to IDLE_LEVEL, so reset never produces a false edge.
- **Debounce counter (per channel)**
  - Width is $clog2(MAX_TIME+1).
  - Clears to 0 in any cycle where s1 != s2. This has priority over tick_ms.
  - Otherwise it increments on tick_ms while below MAX_TIME, and saturates at MAX_TIME.
- **Output update**
  - When the counter equals MAX_TIME and s2 != button_out[i], button_out[i] <= s2 on the next clock.
  - When the counter is not at MAX_TIME, button_out holds.
- **Edge pulses**
  - A delay flop d0 (reset IDLE_LEVEL) follows button_out.
  - button_posedge = ~d0 & button_out and button_negedge = d0 & ~button_out. Both are registered.
- **Long-press counter (per channel)**
  - Width is 16 bits. Cleared whenever button_out[i] == IDLE_LEVEL.
  - While pressed, it increments on tick_ms and saturates at LONG_TIME.
  - button_long[i] pulses for one cycle in the cycle after the counter transitions to LONG_TIME. It fires exactly once per press and does not repeat.
  - A release and a new press restart the count.
- **Channel independence**
  - Channels share only the prescaler.
  - Simultaneous events on several channels are all reported in the same cycle.

## Timing
- **Reset values**
  - button_out = {CH{IDLE_LEVEL}}.
  - button_posedge, button_negedge, button_long and tick_ms are 0.
  - All counters are 0.
- **rst asserted mid-operation**
  - All state returns to reset values on the next clock.
  - Any pending pulse is dropped and none is emitted afterwards.
- **Debounce latency**
  - After the last input transition, button_out changes 2 (sync) + between (MAX_TIME-1)*FREQ*1000 and MAX_TIME*FREQ*1000 + 1 clocks later. The range reflects tick phase.
  - The edge pulse follows button_out by 1 clock.
- **Glitch rejection**
  - Any bounce shorter than (MAX_TIME-1) ms restarts the counter and does not change button_out.
- **Long-press latency**
  - button_long fires LONG_TIME ticks (±1 tick phase) after the debounced press, plus 1 clock.
- **Edge case:** if a release is debounced in the same cycle the long counter would reach LONG_TIME, the clear wins and no button_long pulse is produced.

## Structure
- Package debounce_pkg holds:
  - the localparams for tick period and counter widths;
  - a function returning the debounce-counter width.
- Sub-module key_debounce_channel holds:
  - the synchroniser, debounce counter, output flop, edge flops and long-press counter;
  - one instance per channel, generated CH times.
  - It takes tick_ms as an input.
- The top level contains only the prescaler and the generate loop.

## Test plan
Bench parameters for all scenarios: CH=4, FREQ=1 (1000 clk/tick), MAX_TIME=4, LONG_TIME=10, IDLE_LEVEL=1.

- **Reset:** assert rst for 3 clocks → button_out=4'b1111, all pulses 0, no pulse for 20 000 clocks with inputs held at 1.
- **Clean press:** button_in[0] drops 1→0 and stays low → button_out[0] falls within 3 002–4 003 clocks, one button_negedge[0] pulse, other channels unchanged.
- **Bounce rejection:** toggle button_in[1] every 700 clocks for 10 000 clocks, then hold it low → no change during the toggling, a single negedge after the stable period.
- **Long press:** hold channel 2 low for 20 ms → exactly one button_long[2] pulse about 10 ticks after the negedge. Release → posedge and no further long pulse.
- **Simultaneous events:** press channels 0 and 3 on the same clock → both negedge pulses occur in the same cycle.
- **Mid-operation reset:** assert rst 2 ms into a debounced press on channel 0 → outputs return to reset values, no pulse is emitted, and the press is detected afresh after rst is released.
